pic_init_sequencer: RTL and testbench
=====================================

# pic_init_sequencer

Synchronous command-word sequencer for the 8259A PIC. It decodes CPU writes into ICW1–ICW4 and OCW1–OCW3, and walks the initialization sequence, skipping ICW3 and ICW4 as ICW1 directs. It holds the decoded configuration registers that feed the control logic, IMR, ISR and cascade controller. It also produces the EOI pulse and the write-busy flag that suppresses INT while the PIC is being programmed.

## Interface
- No parameters.
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- wr_strobe  input  1  one-cycle write pulse from read/write logic.
- a0  input  1  address bit A0 sampled with wr_strobe.
- data_in  input  8  write data sampled with wr_strobe.
- second_inta  input  1  one-cycle pulse on the second INTA of an acknowledge cycle.
- icw1, icw2, icw3, icw4  output  8 each  latched init words.
- ocw1  output  8  interrupt mask (IMR contents).
- ocw2  output  8  last OCW2 written.
- ocw3  output  8  last OCW3 written.
- init_done  output  1  high in READY only.
- write_flag  output  1  high while an init sequence is in progress (WAIT_ICW2/3/4).
- eoi  output  1  one-cycle end-of-interrupt pulse.
- eoi_specific  output  1  qualifies eoi: 1 = specific EOI, level given by eoi_level.
- eoi_level  output  3  IR level for a specific EOI.

## Operation
- States: UNINIT (reset state), WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY.
- Write classification, evaluated only when wr_strobe=1:
  - ICW1: a0=0 and data_in[4]=1. Legal in every state.
  - OCW2: a0=0, data_in[4:3]=00.
  - OCW3: a0=0, data_in[4:3]=01.
  - a0=1 writes are data words; their meaning depends on state.
- ICW1 write, in any state including mid-sequence:
  - Latch icw1. Clear ocw1, ocw2, ocw3 and icw4 to 8'h00.
  - Clear icw3 to 8'h00 if data_in[1]=1 (single mode).
  - Go to WAIT_ICW2.
- WAIT_ICW2, a0=1: latch icw2. Next state:
  - WAIT_ICW3 if icw1[1]=0 (cascade mode).
  - otherwise WAIT_ICW4 if icw1[0]=1 (IC4).
  - otherwise READY.
- WAIT_ICW3, a0=1: latch icw3. Next state: WAIT_ICW4 if icw1[0]=1, else READY.
- WAIT_ICW4, a0=1: latch icw4. Go to READY.
- READY, a0=1: latch ocw1.
- READY, OCW2 or OCW3 write: latch ocw2 or ocw3 respectively.
  - OCW2 with data_in[7:5]=001 (non-specific EOI): pulse eoi with eoi_specific=0.
  - OCW2 with data_in[7:5]=011 (specific EOI): pulse eoi with eoi_specific=1 and eoi_level=data_in[2:0].
  - All other OCW2 codes latch only; no pulse.
- Writes that are ignored, with no state or register change:
  - a0=0 non-ICW1 writes in UNINIT, WAIT_ICW2, WAIT_ICW3 or WAIT_ICW4.
  - a0=1 writes in UNINIT.
- second_inta has no effect unless AUTO_EOI_EN is defined (see Configuration).

## Timing
- Reset values: all registers 8'h00, state UNINIT, init_done=0, write_flag=0, eoi=0, eoi_specific=0, eoi_level=3'd0.
- Registers and state update on the rising edge where wr_strobe=1; new values are visible in the following cycle. Write latency is 1 cycle.
- eoi is asserted for exactly one cycle, the cycle after the OCW2 edge. eoi_specific and eoi_level are valid in that same cycle and hold their values afterwards.
- write_flag rises the cycle after an ICW1 write. It falls in the same cycle that init_done rises.
- Back-to-back wr_strobe, one per cycle, must be accepted without loss.
- reset has priority over a concurrent write. Reset mid-sequence returns to UNINIT and discards any partial configuration.
- An OCW2 EOI and an automatic EOI in the same cycle produce a single eoi pulse, carrying the OCW2 qualifiers.

## Configuration
- AUTO_EOI_EN defined:
  - In READY with icw4[1]=1 (AEOI), each second_inta pulse produces eoi with eoi_specific=0 in the following cycle.
- AUTO_EOI_EN undefined:
  - second_inta is ignored and icw4[1] has no effect.
  - EOI is generated only by OCW2.

## Test plan
- Reset, then write ICW1=8'h13 (single, IC4), ICW2=8'h20, ICW4=8'h01. Required: WAIT_ICW3 skipped, icw3=8'h00, init_done=1 one cycle after the ICW4 write, write_flag high for exactly 3 cycles.
- Write ICW1=8'h11 (cascade, IC4), ICW2=8'h40, ICW3=8'h04, ICW4=8'h01. Required: icw3=8'h04, READY reached after the fourth write.
- In READY, write OCW2=8'h63. Required: one-cycle eoi with eoi_specific=1 and eoi_level=3. Then write OCW2=8'h20. Required: eoi with eoi_specific=0.
- Write ICW1=8'h11, ICW2, then ICW1=8'h13 mid-sequence. Required: state back to WAIT_ICW2 and ocw1=8'h00. An a0=1 write of 8'hFF before any ICW1 after reset must leave every register at 8'h00.
- With AUTO_EOI_EN defined and ICW4=8'h03: a second_inta pulse gives eoi one cycle later. A simultaneous OCW2=8'h61 write gives a single eoi with eoi_level=1. With the macro undefined, second_inta produces no eoi.
- Assert reset while in WAIT_ICW3. Required: next cycle is UNINIT, all outputs at reset values, init_done=0, write_flag=0.

Source files
------------

// File: rtl/pic_init_sequencer.sv
// Purpose : 8259A command-word sequencer; decodes CPU writes into ICW1-4 / OCW1-3 and walks the init sequence.
// Latency : 1 cycle from the wr_strobe edge to updated registers, state, init_done/write_flag and eoi.
// Backpressure: none; one write per cycle is always accepted, there is no ready signal.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   wr_strobe, a0,    one-cycle CPU write with address bit A0 and 8-bit data
//   data_in
//   second_inta       one-cycle pulse on the second INTA of an acknowledge cycle
//   icw1..icw4        latched initialization words
//   ocw1, ocw2, ocw3  interrupt mask, last OCW2, last OCW3
//   init_done         high in READY
//   write_flag        high while the init sequence is in progress (suppresses INT)
//   eoi               one-cycle end-of-interrupt pulse
//   eoi_specific,     EOI qualifiers, valid with eoi and held afterwards
//   eoi_level
//
// Build option: define AUTO_EOI_EN to enable automatic EOI on second_inta when ICW4 selects AEOI.

module pic_init_sequencer (
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_strobe,
   input  logic       a0,
   input  logic [7:0] data_in,
   input  logic       second_inta,
   output logic [7:0] icw1,
   output logic [7:0] icw2,
   output logic [7:0] icw3,
   output logic [7:0] icw4,
   output logic [7:0] ocw1,
   output logic [7:0] ocw2,
   output logic [7:0] ocw3,
   output logic       init_done,
   output logic       write_flag,
   output logic       eoi,
   output logic       eoi_specific,
   output logic [2:0] eoi_level
);

   typedef enum logic [2:0] {
      ST_UNINIT    = 3'd0,
      ST_WAIT_ICW2 = 3'd1,
      ST_WAIT_ICW3 = 3'd2,
      ST_WAIT_ICW4 = 3'd3,
      ST_READY     = 3'd4
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] icw1_q, icw1_d;
   logic [7:0] icw2_q, icw2_d;
   logic [7:0] icw3_q, icw3_d;
   logic [7:0] icw4_q, icw4_d;
   logic [7:0] ocw1_q, ocw1_d;
   logic [7:0] ocw2_q, ocw2_d;
   logic [7:0] ocw3_q, ocw3_d;
   logic       init_done_q, init_done_d;
   logic       write_flag_q, write_flag_d;
   logic       eoi_q, eoi_d;
   logic       eoi_specific_q, eoi_specific_d;
   logic [2:0] eoi_level_q, eoi_level_d;

   // Write classification
   logic wr_icw1;
   logic wr_ocw2;
   logic wr_ocw3;
   logic wr_data;
   logic auto_eoi;

   assign wr_icw1 = wr_strobe && !a0 &&  data_in[4];
   assign wr_ocw2 = wr_strobe && !a0 && (data_in[4:3] == 2'b00);
   assign wr_ocw3 = wr_strobe && !a0 && (data_in[4:3] == 2'b01);
   assign wr_data = wr_strobe &&  a0;

`ifdef AUTO_EOI_EN
   // AEOI: every second INTA in READY retires the in-service level non-specifically.
   assign auto_eoi = second_inta && (state_q == ST_READY) && icw4_q[1];
`else
   logic unused_second_inta;
   assign unused_second_inta = second_inta;
   assign auto_eoi           = 1'b0;
`endif

   always_comb begin
      state_d        = state_q;
      icw1_d         = icw1_q;
      icw2_d         = icw2_q;
      icw3_d         = icw3_q;
      icw4_d         = icw4_q;
      ocw1_d         = ocw1_q;
      ocw2_d         = ocw2_q;
      ocw3_d         = ocw3_q;
      eoi_d          = 1'b0;
      eoi_specific_d = eoi_specific_q;
      eoi_level_d    = eoi_level_q;

      if (auto_eoi) begin
         eoi_d          = 1'b1;
         eoi_specific_d = 1'b0;
      end

      if (wr_icw1) begin
         // ICW1 restarts programming from any state and wipes the run-time words.
         icw1_d  = data_in;
         icw4_d  = 8'h00;
         ocw1_d  = 8'h00;
         ocw2_d  = 8'h00;
         ocw3_d  = 8'h00;
         if (data_in[1]) begin
            icw3_d = 8'h00;
         end
         state_d = ST_WAIT_ICW2;
      end else begin
         case (state_q)
            ST_UNINIT: begin
               // Nothing is meaningful until ICW1 arrives.
            end
            ST_WAIT_ICW2: begin
               if (wr_data) begin
                  icw2_d = data_in;
                  if (!icw1_q[1]) begin
                     state_d = ST_WAIT_ICW3;
                  end else if (icw1_q[0]) begin
                     state_d = ST_WAIT_ICW4;
                  end else begin
                     state_d = ST_READY;
                  end
               end
            end
            ST_WAIT_ICW3: begin
               if (wr_data) begin
                  icw3_d  = data_in;
                  state_d = icw1_q[0] ? ST_WAIT_ICW4 : ST_READY;
               end
            end
            ST_WAIT_ICW4: begin
               if (wr_data) begin
                  icw4_d  = data_in;
                  state_d = ST_READY;
               end
            end
            ST_READY: begin
               if (wr_data) begin
                  ocw1_d = data_in;
               end
               if (wr_ocw3) begin
                  ocw3_d = data_in;
               end
               if (wr_ocw2) begin
                  ocw2_d = data_in;
                  // OCW2 EOI overrides a coincident automatic EOI's qualifiers.
                  if (data_in[7:5] == 3'b001) begin
                     eoi_d          = 1'b1;
                     eoi_specific_d = 1'b0;
                  end else if (data_in[7:5] == 3'b011) begin
                     eoi_d          = 1'b1;
                     eoi_specific_d = 1'b1;
                     eoi_level_d    = data_in[2:0];
                  end
               end
            end
            default: begin
               state_d = ST_UNINIT;
            end
         endcase
      end

      // Status flags are registered from the next state so they line up with it.
      init_done_d  = (state_d == ST_READY);
      write_flag_d = (state_d == ST_WAIT_ICW2) ||
                     (state_d == ST_WAIT_ICW3) ||
                     (state_d == ST_WAIT_ICW4);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= ST_UNINIT;
         icw1_q         <= 8'h00;
         icw2_q         <= 8'h00;
         icw3_q         <= 8'h00;
         icw4_q         <= 8'h00;
         ocw1_q         <= 8'h00;
         ocw2_q         <= 8'h00;
         ocw3_q         <= 8'h00;
         init_done_q    <= 1'b0;
         write_flag_q   <= 1'b0;
         eoi_q          <= 1'b0;
         eoi_specific_q <= 1'b0;
         eoi_level_q    <= 3'd0;
      end else begin
         state_q        <= state_d;
         icw1_q         <= icw1_d;
         icw2_q         <= icw2_d;
         icw3_q         <= icw3_d;
         icw4_q         <= icw4_d;
         ocw1_q         <= ocw1_d;
         ocw2_q         <= ocw2_d;
         ocw3_q         <= ocw3_d;
         init_done_q    <= init_done_d;
         write_flag_q   <= write_flag_d;
         eoi_q          <= eoi_d;
         eoi_specific_q <= eoi_specific_d;
         eoi_level_q    <= eoi_level_d;
      end
   end

   assign icw1         = icw1_q;
   assign icw2         = icw2_q;
   assign icw3         = icw3_q;
   assign icw4         = icw4_q;
   assign ocw1         = ocw1_q;
   assign ocw2         = ocw2_q;
   assign ocw3         = ocw3_q;
   assign init_done    = init_done_q;
   assign write_flag   = write_flag_q;
   assign eoi          = eoi_q;
   assign eoi_specific = eoi_specific_q;
   assign eoi_level    = eoi_level_q;

endmodule

// File: tb/tb_pic_init_sequencer.sv
// Purpose : self-checking bench for pic_init_sequencer (vector table, corner sequences, random vs model).
// Latency : checks every output 1 cycle after each driven edge.
// Backpressure: n/a; the bench drives at most one write per cycle.

module tb_pic_init_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       wr_strobe = 1'b0;
   logic       a0 = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       second_inta = 1'b0;
   logic [7:0] icw1, icw2, icw3, icw4, ocw1, ocw2, ocw3;
   logic       init_done, write_flag, eoi, eoi_specific;
   logic [2:0] eoi_level;

   int vectors = 0;
   int miscompares = 0;

   pic_init_sequencer dut (
      .clk          (clk),
      .reset        (reset),
      .wr_strobe    (wr_strobe),
      .a0           (a0),
      .data_in      (data_in),
      .second_inta  (second_inta),
      .icw1         (icw1),
      .icw2         (icw2),
      .icw3         (icw3),
      .icw4         (icw4),
      .ocw1         (ocw1),
      .ocw2         (ocw2),
      .ocw3         (ocw3),
      .init_done    (init_done),
      .write_flag   (write_flag),
      .eoi          (eoi),
      .eoi_specific (eoi_specific),
      .eoi_level    (eoi_level)
   );

   always #5 clk = ~clk;

   // Reference model: register file indexed 0..6 = icw1..icw4, ocw1..ocw3.
   // Programming is a queue of the data words still owed after ICW1.
   logic [7:0] m_reg [7];
   int         m_pend [$];
   bit         m_started;
   bit         m_eoi;
   bit         m_spec;
   logic [2:0] m_lvl;

   task automatic model_step(input bit rst, input bit wr, input bit a0v,
                             input logic [7:0] d, input bit si);
      bit         ev;
      bit         sp;
      logic [2:0] lv;
      bit         ready_now;
      ev = 1'b0;
      sp = m_spec;
      lv = m_lvl;
      if (rst) begin
         for (int i = 0; i < 7; i++) m_reg[i] = 8'h00;
         m_pend.delete();
         m_started = 1'b0;
         m_eoi = 1'b0;
         m_spec = 1'b0;
         m_lvl = 3'd0;
         return;
      end
      ready_now = m_started && (m_pend.size() == 0);
`ifdef AUTO_EOI_EN
      if (si && ready_now && m_reg[3][1]) begin
         ev = 1'b1;
         sp = 1'b0;
      end
`else
      if (si) ev = ev;
`endif
      if (wr) begin
         if (!a0v && d[4]) begin
            m_reg[0] = d;
            m_reg[3] = 8'h00;
            m_reg[4] = 8'h00;
            m_reg[5] = 8'h00;
            m_reg[6] = 8'h00;
            if (d[1]) m_reg[2] = 8'h00;
            m_pend.delete();
            m_pend.push_back(1);
            if (!d[1]) m_pend.push_back(2);
            if (d[0])  m_pend.push_back(3);
            m_started = 1'b1;
         end else if (a0v) begin
            if (m_pend.size() > 0) m_reg[m_pend.pop_front()] = d;
            else if (m_started)    m_reg[4] = d;
         end else if (ready_now) begin
            if (d[3]) begin
               m_reg[6] = d;
            end else begin
               m_reg[5] = d;
               if (d[7:5] == 3'd1) begin
                  ev = 1'b1; sp = 1'b0;
               end else if (d[7:5] == 3'd3) begin
                  ev = 1'b1; sp = 1'b1; lv = d[2:0];
               end
            end
         end
      end
      m_eoi  = ev;
      m_spec = sp;
      m_lvl  = lv;
   endtask

   function automatic logic [62:0] model_vec();
      return {m_reg[0], m_reg[1], m_reg[2], m_reg[3], m_reg[4], m_reg[5], m_reg[6],
              m_started && (m_pend.size() == 0), m_pend.size() != 0,
              m_eoi, m_spec, m_lvl};
   endfunction

   function automatic logic [62:0] dut_vec();
      return {icw1, icw2, icw3, icw4, ocw1, ocw2, ocw3,
              init_done, write_flag, eoi, eoi_specific, eoi_level};
   endfunction

   function automatic logic [7:0] dut_reg(input int sel);
      case (sel)
         0: return icw1;
         1: return icw2;
         2: return icw3;
         3: return icw4;
         4: return ocw1;
         5: return ocw2;
         default: return ocw3;
      endcase
   endfunction

   task automatic check(input string name, input logic [62:0] got, input logic [62:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // One clock: drive, let the edge happen, advance the model, compare everything.
   task automatic step(input bit rst, input bit wr, input bit a0v,
                       input logic [7:0] d, input bit si);
      reset       = rst;
      wr_strobe   = wr;
      a0          = a0v;
      data_in     = d;
      second_inta = si;
      @(posedge clk);
      model_step(rst, wr, a0v, d, si);
      #1;
      reset       = 1'b0;
      wr_strobe   = 1'b0;
      second_inta = 1'b0;
      check("model", dut_vec(), model_vec());
   endtask

   typedef struct {
      bit         rst;
      bit         wr;
      bit         a0;
      logic [7:0] d;
      bit         si;
      bit         x_done;
      bit         x_wf;
      bit         x_eoi;
      bit         x_spec;
      logic [2:0] x_lvl;
      int         reg_sel;   // -1 = no register check
      logic [7:0] reg_val;
   } vec_t;

   vec_t tbl [26];

   function automatic vec_t mk(input bit rst, input bit wr, input bit a0v, input logic [7:0] d,
                               input bit dn, input bit wf, input bit ev, input bit sp,
                               input logic [2:0] lv, input int sel, input logic [7:0] val);
      vec_t v;
      v.rst = rst; v.wr = wr; v.a0 = a0v; v.d = d; v.si = 1'b0;
      v.x_done = dn; v.x_wf = wf; v.x_eoi = ev; v.x_spec = sp; v.x_lvl = lv;
      v.reg_sel = sel; v.reg_val = val;
      return v;
   endfunction

   initial begin
      int wf_cycles;
      logic [7:0] d;
      bit rr, ww, aa, ss;

      for (int i = 0; i < 7; i++) m_reg[i] = 8'h00;
      m_started = 1'b0; m_eoi = 1'b0; m_spec = 1'b0; m_lvl = 3'd0;

      //             rst wr a0 data   done wf eoi spc lvl sel val
      tbl[0]  = mk(1, 0, 0, 8'h00,  0, 0, 0, 0, 0, -1, 8'h00);
      tbl[1]  = mk(0, 1, 1, 8'hFF,  0, 0, 0, 0, 0,  4, 8'h00);
      tbl[2]  = mk(0, 1, 0, 8'h20,  0, 0, 0, 0, 0,  5, 8'h00);
      tbl[3]  = mk(0, 1, 0, 8'h13,  0, 1, 0, 0, 0,  0, 8'h13);
      tbl[4]  = mk(0, 0, 0, 8'h00,  0, 1, 0, 0, 0, -1, 8'h00);
      tbl[5]  = mk(0, 1, 0, 8'h20,  0, 1, 0, 0, 0,  5, 8'h00);
      tbl[6]  = mk(0, 1, 1, 8'h20,  0, 1, 0, 0, 0,  1, 8'h20);
      tbl[7]  = mk(0, 1, 1, 8'h01,  1, 0, 0, 0, 0,  2, 8'h00);
      tbl[8]  = mk(0, 1, 0, 8'h63,  1, 0, 1, 1, 3,  5, 8'h63);
      tbl[9]  = mk(0, 0, 0, 8'h00,  1, 0, 0, 1, 3, -1, 8'h00);
      tbl[10] = mk(0, 1, 0, 8'h20,  1, 0, 1, 0, 3,  5, 8'h20);
      tbl[11] = mk(0, 0, 0, 8'h00,  1, 0, 0, 0, 3, -1, 8'h00);
      tbl[12] = mk(0, 1, 0, 8'h11,  0, 1, 0, 0, 3, -1, 8'h00);
      tbl[13] = mk(0, 1, 1, 8'h40,  0, 1, 0, 0, 3,  1, 8'h40);
      tbl[14] = mk(1, 1, 1, 8'h04,  0, 0, 0, 0, 0,  2, 8'h00);
      tbl[15] = mk(0, 1, 0, 8'h11,  0, 1, 0, 0, 0, -1, 8'h00);
      tbl[16] = mk(0, 1, 1, 8'h40,  0, 1, 0, 0, 0, -1, 8'h00);
      tbl[17] = mk(0, 1, 1, 8'h04,  0, 1, 0, 0, 0,  2, 8'h04);
      tbl[18] = mk(0, 1, 1, 8'h01,  1, 0, 0, 0, 0,  3, 8'h01);
      tbl[19] = mk(0, 1, 1, 8'hA5,  1, 0, 0, 0, 0,  4, 8'hA5);
      tbl[20] = mk(0, 1, 0, 8'h0B,  1, 0, 0, 0, 0,  6, 8'h0B);
      tbl[21] = mk(0, 1, 0, 8'h40,  1, 0, 0, 0, 0,  5, 8'h40);
      tbl[22] = mk(0, 1, 0, 8'h11,  0, 1, 0, 0, 0,  2, 8'h04);
      tbl[23] = mk(0, 1, 1, 8'h40,  0, 1, 0, 0, 0, -1, 8'h00);
      tbl[24] = mk(0, 1, 0, 8'h13,  0, 1, 0, 0, 0,  4, 8'h00);
      tbl[25] = mk(0, 1, 1, 8'h08,  0, 1, 0, 0, 0,  2, 8'h00);

      for (int i = 0; i < 26; i++) begin
         step(tbl[i].rst, tbl[i].wr, tbl[i].a0, tbl[i].d, tbl[i].si);
         check($sformatf("row%0d_flags", i),
               {58'd0, init_done, write_flag, eoi, eoi_specific, eoi_level},
               {58'd0, tbl[i].x_done, tbl[i].x_wf, tbl[i].x_eoi, tbl[i].x_spec, tbl[i].x_lvl});
         if (tbl[i].reg_sel >= 0)
            check($sformatf("row%0d_reg%0d", i, tbl[i].reg_sel),
                  {55'd0, dut_reg(tbl[i].reg_sel)}, {55'd0, tbl[i].reg_val});
      end

      // Finish programming with AEOI set, then exercise second_inta alone and
      // coincident with a specific-EOI OCW2.
      step(0, 1, 1, 8'h03, 0);
      check("aeoi_ready", {62'd0, init_done}, 63'd1);
      step(0, 0, 0, 8'h00, 1);
`ifdef AUTO_EOI_EN
      check("aeoi_pulse", {61'd0, eoi, eoi_specific}, {61'd0, 1'b1, 1'b0});
`else
      check("inta_ignored", {61'd0, eoi, eoi_specific}, {61'd0, 1'b0, 1'b0});
`endif
      step(0, 0, 0, 8'h00, 0);
      check("aeoi_clear", {62'd0, eoi}, 63'd0);
      step(0, 1, 0, 8'h61, 1);
      check("eoi_merge", {58'd0, eoi, eoi_specific, eoi_level}, {58'd0, 1'b1, 1'b1, 3'd1});
      step(0, 0, 0, 8'h00, 0);
      check("eoi_single", {62'd0, eoi}, 63'd0);

      // write_flag span: ICW1, a gap cycle, ICW2, ICW4 -> high for 3 cycles.
      wf_cycles = 0;
      step(1, 0, 0, 8'h00, 0);
      step(0, 1, 0, 8'h13, 0); wf_cycles += int'(write_flag);
      step(0, 0, 0, 8'h00, 0); wf_cycles += int'(write_flag);
      step(0, 1, 1, 8'h20, 0); wf_cycles += int'(write_flag);
      check("no_icw3_wait", {62'd0, write_flag}, 63'd1);
      step(0, 1, 1, 8'h01, 0); wf_cycles += int'(write_flag);
      check("done_after_icw4", {61'd0, init_done, write_flag}, {61'd0, 1'b1, 1'b0});
      step(0, 0, 0, 8'h00, 0); wf_cycles += int'(write_flag);
      check("wf_span", 63'(wf_cycles), 63'd3);

      // Randomized traffic against the model.
      for (int n = 0; n < 4000; n++) begin
         rr = ($urandom_range(63) == 0);
         ww = $urandom_range(1) == 1;
         aa = $urandom_range(1) == 1;
         ss = ($urandom_range(3) == 0);
         d  = 8'($urandom);
         if (!aa) begin
            if ($urandom_range(7) == 0) begin
               d[4] = 1'b1;
            end else begin
               d[4] = 1'b0;
               case ($urandom_range(3))
                  0: d[7:5] = 3'b001;
                  1: d[7:5] = 3'b011;
                  default: ;
               endcase
            end
         end
         step(rr, ww, aa, d, ss);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
